frame_scanout: RTL and testbench
================================

Name: frame_scanout

Overview:
- Consumer end of the frame-buffer copy handshake. On each frame tick it raises a one-cycle request with a target time, waits for the copy-complete pulse from the frame writer, then reads every channel word from the frame buffer.
- Each word is shifted out MSB-first on a serial clock/data pair to the daisy-chained LED driver boards, followed by a latch pulse.
- Sits between the frame buffer read port and the LED board pins.

Parameters:
- c_ledboards, 30, number of daisy-chained LED boards.
- c_max_time, 1024, target-time modulus.
- c_channels, c_ledboards*32, channel words per frame.
- c_addr_w, $clog2(c_channels), buffer address width.
- c_time_w, $clog2(c_max_time), target-time width.
- c_data_w, 16, bits per channel word.
- c_frame_cycles, 100000, clock cycles per frame tick; must be > c_channels*(2+2*c_data_w)+8.

Ports:
- i_clk input 1 system clock; all logic on rising edge.
- i_rst input 1 asynchronous, active-high reset.
- i_en input 1 enables the frame tick counter.
- i_done input 1 copy-complete pulse from the frame writer.
- i_rdata input c_data_w frame buffer read data, valid one cycle after o_ren.
- o_drq output 1 frame request pulse.
- o_target_time output c_time_w time of requested frame.
- o_raddr output c_addr_w frame buffer read address.
- o_ren output 1 frame buffer read enable.
- o_sclk output 1 serial clock to LED boards.
- o_sdata output 1 serial data to LED boards.
- o_latch output 1 latch pulse to LED boards.
- o_busy output 1 high whenever state != IDLE.
- o_overrun output 1 pulse when a tick is dropped.

Behaviour:
- Reset (async, any state): state=IDLE, tick counter=0, o_target_time=0, all other outputs 0, shift register and counters 0.
- Tick counter:
  - Counts while i_en=1; holds its value while i_en=0.
  - At value c_frame_cycles-1 it asserts tick for one cycle and wraps to 0.
- IDLE: on tick go to REQ.
- REQ: o_drq=1 for exactly one cycle; next state WAIT.
- WAIT:
  - Stay until i_done=1, then set o_raddr=c_channels-1 and go to READ.
  - No timeout. i_done in any other state is ignored.
- READ: o_ren=1 with o_raddr for one cycle; next state LOAD.
- LOAD: capture i_rdata into the shift register, bit count=c_data_w-1; next state SHIFT, phase 0.
- SHIFT (two cycles per bit):
  - Phase 0: o_sclk=0, o_sdata=shift register MSB.
  - Phase 1: o_sclk=1, o_sdata unchanged. At the end of phase 1 shift left by one.
  - If bit count==0: when o_raddr==0 go to LATCH; otherwise decrement o_raddr and go to READ.
  - If bit count!=0: decrement bit count and return to phase 0.
- Per-channel cost: 2+2*c_data_w cycles.
- Channel order: highest address first, so address 0 ends up in the nearest board.
- LATCH:
  - o_latch=1 for one cycle, o_sclk=0.
  - o_target_time increments, wrapping from c_max_time-1 to 0.
  - Next state IDLE.
- o_target_time is stable from REQ through LATCH; it is the time of the frame being requested and shifted.
- Tick arriving while state != IDLE: tick is dropped, o_overrun=1 for that cycle, the frame in progress is unaffected.
- i_en deasserted mid-frame: the current frame completes; no new ticks occur.
- Outside SHIFT: o_sclk=0 and o_sdata=0. o_ren=0 outside READ.

Test Plan:
- Common parameters for all scenarios: c_ledboards=1 (32 channels), c_data_w=4, c_frame_cycles=400.
- Reset, then i_en=1 → o_drq pulses exactly one cycle at cycle 400 with o_target_time=0; no o_ren until i_done.
- i_done 5 cycles after o_drq; buffer word[a]=a[3:0] →
  - o_ren addresses go 31,30,...,0;
  - 128 rising edges of o_sclk, and sampling o_sdata on each rising edge reproduces the words in that order;
  - one o_latch pulse;
  - o_target_time becomes 1.
- Preload o_target_time=1023 (run 1023 frames, or force with c_max_time=4 and run 3 frames) → after the next latch o_target_time=0.
- Withhold i_done past the next tick → o_overrun pulses one cycle, only one o_drq is seen; completing i_done then finishes the frame normally.
- Assert i_rst mid-SHIFT → all outputs 0 immediately (asynchronous); after release, the first o_drq appears 400 cycles later with o_target_time=0.
- Pulse i_done while in IDLE and while in SHIFT → ignored: no state change and no extra reads.

Source files
------------

// File: rtl/frame_scanout.sv
// Frame scan-out: on each frame tick request a frame, await copy-complete, then shift every channel word MSB-first to the LED chain.
// Latency: o_drq one cycle after tick; per channel 2+2*c_data_w cycles, highest address first, then one latch cycle.
// Backpressure: none; a tick arriving while a frame is in flight is dropped and flagged on o_overrun.
module frame_scanout #(
    parameter int c_ledboards    = 30,
    parameter int c_max_time     = 1024,
    parameter int c_channels     = c_ledboards * 32,
    parameter int c_addr_w       = $clog2(c_channels),
    parameter int c_time_w       = $clog2(c_max_time),
    parameter int c_data_w       = 16,
    parameter int c_frame_cycles = 100000
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic                i_done,
    input  logic [c_data_w-1:0] i_rdata,
    output logic                o_drq,
    output logic [c_time_w-1:0] o_target_time,
    output logic [c_addr_w-1:0] o_raddr,
    output logic                o_ren,
    output logic                o_sclk,
    output logic                o_sdata,
    output logic                o_latch,
    output logic                o_busy,
    output logic                o_overrun
);

    localparam int c_cnt_w = $clog2(c_frame_cycles);
    localparam int c_bit_w = (c_data_w > 1) ? $clog2(c_data_w) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, READ, LOAD, SHIFT, LATCH} state_t;

    state_t              state, state_nxt;
    logic [c_cnt_w-1:0]  tick_cnt, tick_cnt_nxt;
    logic [c_time_w-1:0] target_time, target_time_nxt;
    logic [c_addr_w-1:0] raddr, raddr_nxt;
    logic [c_data_w-1:0] sreg, sreg_nxt;
    logic [c_bit_w-1:0]  bit_cnt, bit_cnt_nxt;
    logic                phase, phase_nxt;
    logic                tick;

    // Gating with i_en keeps a counter parked on its last value from ticking forever.
    assign tick = i_en && (tick_cnt == c_cnt_w'(c_frame_cycles - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            target_time <= '0;
            raddr       <= '0;
            sreg        <= '0;
            bit_cnt     <= '0;
            phase       <= 1'b0;
        end else begin
            state       <= state_nxt;
            tick_cnt    <= tick_cnt_nxt;
            target_time <= target_time_nxt;
            raddr       <= raddr_nxt;
            sreg        <= sreg_nxt;
            bit_cnt     <= bit_cnt_nxt;
            phase       <= phase_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        tick_cnt_nxt    = tick_cnt;
        target_time_nxt = target_time;
        raddr_nxt       = raddr;
        sreg_nxt        = sreg;
        bit_cnt_nxt     = bit_cnt;
        phase_nxt       = phase;

        if (tick) begin
            tick_cnt_nxt = '0;
        end else if (i_en) begin
            tick_cnt_nxt = tick_cnt + 1'b1;
        end

        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (i_done) begin
                    raddr_nxt = c_addr_w'(c_channels - 1);
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                sreg_nxt    = i_rdata;
                bit_cnt_nxt = c_bit_w'(c_data_w - 1);
                phase_nxt   = 1'b0;
                state_nxt   = SHIFT;
            end
            SHIFT: begin
                if (!phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    sreg_nxt  = sreg << 1;
                    if (bit_cnt == '0) begin
                        if (raddr == '0) begin
                            state_nxt = LATCH;
                        end else begin
                            raddr_nxt = raddr - 1'b1;
                            state_nxt = READ;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt - 1'b1;
                    end
                end
            end
            LATCH: begin
                target_time_nxt = (target_time == c_time_w'(c_max_time - 1)) ? '0 : target_time + 1'b1;
                state_nxt       = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode directly from reset registers so an async reset clears them at once.
    assign o_drq         = (state == REQ);
    assign o_ren         = (state == READ);
    assign o_latch       = (state == LATCH);
    assign o_busy        = (state != IDLE);
    assign o_sclk        = (state == SHIFT) && phase;
    assign o_sdata       = (state == SHIFT) && sreg[c_data_w-1];
    assign o_overrun     = tick && (state != IDLE);
    assign o_raddr       = raddr;
    assign o_target_time = target_time;

endmodule

// File: tb/tb_frame_scanout.sv
// Bench for frame_scanout: table of frames checked against a memory/bit-stream model, plus overrun, reset and stray-done sequences.
module tb_frame_scanout;

    localparam int MT = 4;
    localparam int DW = 4;
    localparam int FC = 400;
    localparam int CH = 32;
    localparam int AW = 5;
    localparam int TW = 2;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_en;
    logic          i_done;
    logic [DW-1:0] i_rdata = '0;
    logic          o_drq;
    logic [TW-1:0] o_target_time;
    logic [AW-1:0] o_raddr;
    logic          o_ren;
    logic          o_sclk;
    logic          o_sdata;
    logic          o_latch;
    logic          o_busy;
    logic          o_overrun;

    frame_scanout #(
        .c_ledboards(1),
        .c_max_time(MT),
        .c_data_w(DW),
        .c_frame_cycles(FC)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_en(i_en),
        .i_done(i_done),
        .i_rdata(i_rdata),
        .o_drq(o_drq),
        .o_target_time(o_target_time),
        .o_raddr(o_raddr),
        .o_ren(o_ren),
        .o_sclk(o_sclk),
        .o_sdata(o_sdata),
        .o_latch(o_latch),
        .o_busy(o_busy),
        .o_overrun(o_overrun)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [CH];
    int  addr_q[$];
    bit  bit_q[$];
    int  drq_cnt, latch_cnt, ovr_cnt, ren_cnt;
    logic prev_sclk = 1'b0;

    typedef struct {
        int delay;
        bit rnd;
        int exp_t0;
        int exp_t1;
    } vec_t;
    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Frame buffer model and output monitor, sampled just after each rising edge.
    always begin
        @(posedge i_clk);
        #1;
        if (o_ren) begin
            addr_q.push_back(int'(o_raddr));
            i_rdata = mem[o_raddr];
            ren_cnt++;
        end
        if (o_sclk && !prev_sclk) bit_q.push_back(o_sdata);
        prev_sclk = o_sclk;
        drq_cnt   += int'(o_drq);
        latch_cnt += int'(o_latch);
        ovr_cnt   += int'(o_overrun);
    end

    task automatic clear_mon();
        addr_q.delete();
        bit_q.delete();
        drq_cnt = 0;
        latch_cnt = 0;
        ovr_cnt = 0;
        ren_cnt = 0;
    endtask

    task automatic wait_drq(output int n);
        n = 0;
        do begin
            @(negedge i_clk);
            n++;
        end while (!o_drq && n < 1000);
        check("drq_seen", o_drq, 1);
    endtask

    task automatic pulse_done(input int delay);
        repeat (delay) @(negedge i_clk);
        check("no_read_before_done", ren_cnt, 0);
        i_done = 1'b1;
        @(negedge i_clk);
        i_done = 1'b0;
    endtask

    task automatic wait_sclk();
        int n = 0;
        while (!o_sclk && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        check("sclk_seen", o_sclk, 1);
    endtask

    task automatic wait_latch();
        int n = 0;
        while (latch_cnt == 0 && n < 1000) begin
            @(negedge i_clk);
            n++;
        end
        check("latch_seen", (latch_cnt > 0), 1);
        @(negedge i_clk);
        check("idle_after_latch", o_busy, 0);
    endtask

    // Expected stream: channels from the top address down, each word MSB first.
    task automatic check_frame(input string tag, input int exp_ovr);
        bit exp_bits[$];
        int bad_a = 0;
        int bad_b = 0;
        for (int a = CH - 1; a >= 0; a--)
            for (int b = DW - 1; b >= 0; b--) exp_bits.push_back(mem[a][b]);
        check({tag, "_nreads"}, addr_q.size(), CH);
        for (int i = 0; i < addr_q.size() && i < CH; i++)
            if (addr_q[i] != CH - 1 - i) bad_a++;
        check({tag, "_addr_order"}, bad_a, 0);
        check({tag, "_nbits"}, bit_q.size(), CH * DW);
        for (int i = 0; i < bit_q.size() && i < exp_bits.size(); i++)
            if (bit_q[i] != exp_bits[i]) bad_b++;
        check({tag, "_bits"}, bad_b, 0);
        check({tag, "_latches"}, latch_cnt, 1);
        check({tag, "_drq_cycles"}, drq_cnt, 1);
        check({tag, "_overrun_cycles"}, ovr_cnt, exp_ovr);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int busy_seen;

        tbl[0] = '{delay: 5,  rnd: 1'b0, exp_t0: 0, exp_t1: 1};
        tbl[1] = '{delay: 1,  rnd: 1'b1, exp_t0: 1, exp_t1: 2};
        tbl[2] = '{delay: 12, rnd: 1'b1, exp_t0: 2, exp_t1: 3};
        tbl[3] = '{delay: 40, rnd: 1'b1, exp_t0: 3, exp_t1: 0};
        tbl[4] = '{delay: 3,  rnd: 1'b1, exp_t0: 0, exp_t1: 1};

        for (int a = 0; a < CH; a++) mem[a] = DW'(a);
        i_rst  = 1'b1;
        i_en   = 1'b0;
        i_done = 1'b0;
        repeat (3) @(negedge i_clk);
        check("reset_outputs", {o_drq, o_target_time, o_raddr, o_ren, o_sclk, o_sdata,
                                o_latch, o_busy, o_overrun}, 0);
        i_rst = 1'b0;
        @(negedge i_clk);
        clear_mon();
        i_en = 1'b1;
        wait_drq(n);
        check("first_tick_latency", n, FC);

        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                clear_mon();
                wait_drq(n);
            end
            check($sformatf("v%0d_time_at_drq", i), o_target_time, tbl[i].exp_t0);
            if (tbl[i].rnd)
                for (int a = 0; a < CH; a++) mem[a] = DW'($urandom);
            pulse_done(tbl[i].delay);
            wait_latch();
            check_frame($sformatf("v%0d", i), 0);
            check($sformatf("v%0d_time_after", i), o_target_time, tbl[i].exp_t1);
        end

        // Withhold done past the next tick.
        clear_mon();
        wait_drq(n);
        n = 0;
        while (!o_overrun && n < 600) begin
            @(negedge i_clk);
            n++;
        end
        check("overrun_seen", o_overrun, 1);
        repeat (20) @(negedge i_clk);
        check("overrun_still_busy", o_busy, 1);
        check("overrun_single_drq", drq_cnt, 1);
        pulse_done(1);
        wait_latch();
        check_frame("ovr", 1);
        check("ovr_time_after", o_target_time, 2);

        // Stray done while idle.
        clear_mon();
        i_done = 1'b1;
        @(negedge i_clk);
        i_done = 1'b0;
        busy_seen = 0;
        repeat (6) begin
            @(negedge i_clk);
            busy_seen += int'(o_busy);
        end
        check("idle_done_ignored_busy", busy_seen, 0);
        check("idle_done_ignored_reads", ren_cnt, 0);

        // Stray done mid-shift, and enable dropped mid-frame.
        clear_mon();
        wait_drq(n);
        for (int a = 0; a < CH; a++) mem[a] = DW'($urandom);
        pulse_done(2);
        wait_sclk();
        i_done = 1'b1;
        i_en   = 1'b0;
        @(negedge i_clk);
        i_done = 1'b0;
        wait_latch();
        check_frame("spur", 0);
        check("spur_time_after", o_target_time, 3);
        repeat (900) @(negedge i_clk);
        check("en_off_no_drq", drq_cnt, 1);

        // Asynchronous reset in the middle of shifting.
        i_en = 1'b1;
        clear_mon();
        wait_drq(n);
        pulse_done(1);
        wait_sclk();
        #2;
        i_rst = 1'b1;
        #1;
        check("async_reset_outputs", {o_drq, o_target_time, o_raddr, o_ren, o_sclk, o_sdata,
                                      o_latch, o_busy, o_overrun}, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        clear_mon();
        wait_drq(n);
        check("post_reset_tick_latency", n, FC);
        check("post_reset_time", o_target_time, 0);
        for (int a = 0; a < CH; a++) mem[a] = DW'($urandom);
        pulse_done(5);
        wait_latch();
        check_frame("rst", 0);
        check("rst_time_after", o_target_time, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
